// File: rtl/bd_dma_pkg.sv
// Shared definitions for the BD DMA completion path: BD geometry, RC
// descriptor field offsets, MRRS codes and small decode helpers.
package bd_dma_pkg;

  localparam int BD_W      = 256;
  localparam int DW_PER_BD = 8;

  // RC completion descriptor layout (first beat, DW0..DW2)
  localparam int RC_DWCNT_LSB   = 32;
  localparam int RC_DWCNT_W     = 11;
  localparam int RC_STATUS_LSB  = 43;
  localparam int RC_POISON_BIT  = 46;
  localparam int RC_TAG_LSB     = 64;
  localparam int RC_PAYLOAD_LSB = 96;

  // Payload carried by the first beat (DW3..DW7) and held for realignment
  localparam int HOLD_W = BD_W - RC_PAYLOAD_LSB;

  // MRRS codes; anything else is treated as 512 bytes (16 BDs)
  localparam logic [2:0] MRRS_128 = 3'b000;
  localparam logic [2:0] MRRS_256 = 3'b001;

  typedef struct packed {
    logic [RC_DWCNT_W-1:0] dword_count;
    logic [2:0]            status;
    logic                  poisoned;
  } rc_desc_t;

  function automatic rc_desc_t rc_decode(input logic [BD_W-1:0] beat);
    rc_desc_t d;
    d.dword_count = beat[RC_DWCNT_LSB +: RC_DWCNT_W];
    d.status      = beat[RC_STATUS_LSB +: 3];
    d.poisoned    = beat[RC_POISON_BIT];
    return d;
  endfunction

  // BDs per sub-request for a given MRRS code
  function automatic logic [4:0] mrrs_bds(input logic [2:0] code);
    case (code)
      MRRS_128: return 5'd4;
      MRRS_256: return 5'd8;
      default:  return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/bd_reorder_buf.sv
// Reorder buffer: one dedicated entry per BD of the current request, a valid
// bit per entry, a random-access write port and a read port that can retire
// the entry it is looking at.
module bd_reorder_buf
  import bd_dma_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             user_clk,
  input  logic             user_reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [BD_W-1:0]  wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             rd_clr,
  output logic             rd_valid,
  output logic [BD_W-1:0]  rd_data
);

  logic [BD_W-1:0]  mem [DEPTH];
  logic [DEPTH-1:0] valid;

  // BD storage write port
  // NOTE: storage has no reset; the valid bits alone decide what is readable,
  // so resetting 16x256 flops would buy nothing. Sequential state always uses
  // non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge user_clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Valid bits: a write sets, a retire clears; a same-entry collision keeps the write
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      valid <= '0;
    end else begin
      if (rd_clr) valid[rd_idx] <= 1'b0;
      if (wr_en)  valid[wr_idx] <= 1'b1;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_data  = mem[rd_idx];

endmodule

// File: rtl/bd_cpld_recv.sv
// BD completion receiver: realigns RC completion payload into whole BDs,
// places each BD at its request-relative index and streams them out in order.
module bd_cpld_recv
  import bd_dma_pkg::*;
#(
  parameter int MAX_BD = 16,
  parameter int IDX_W  = 4,
  parameter int SLOT_W = 2
) (
  input  logic            user_clk,
  input  logic            user_reset,
  input  logic [2:0]      cfg_max_rd_req_size,
  input  logic            req_start,
  input  logic [4:0]      req_bd_num,
  input  logic [4:0]      req_first_size,
  output logic            req_ready,
  input  logic            s_axis_rc_tvalid,
  output logic            s_axis_rc_tready,
  input  logic [BD_W-1:0] s_axis_rc_tdata,
  input  logic            s_axis_rc_tlast,
  output logic            m_axis_bd_tvalid,
  input  logic            m_axis_bd_tready,
  output logic [BD_W-1:0] m_axis_bd_tdata,
  output logic            m_axis_bd_tlast,
  output logic            bd_cpl_err
);

  localparam int NSLOT = 1 << SLOT_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]        state;
  logic [4:0]        bd_num, first_size, max_size;
  logic [4:0]        slot_cnt [NSLOT];
  logic [SLOT_W-1:0] cur_slot;
  logic [4:0]        wr_idx;
  logic              drop;
  logic [HOLD_W-1:0] hold;
  logic [IDX_W-1:0]  rd_ptr;

  logic              busy, rc_fire, bd_fire;
  rc_desc_t          desc;
  logic [SLOT_W-1:0] hdr_slot;
  logic [4:0]        hdr_base, hdr_idx;
  logic              hdr_bad;
  logic              buf_wr_en;
  logic              rd_valid;

  assign busy             = (state != S_IDLE);
  assign req_ready        = ~busy;
  assign s_axis_rc_tready = busy;
  assign rc_fire          = s_axis_rc_tvalid & busy;
  assign desc             = rc_decode(s_axis_rc_tdata);
  assign hdr_slot         = s_axis_rc_tdata[RC_TAG_LSB +: SLOT_W];

  // Header decode: buffer index of the TLP's first BD and drop decision
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hdr_base = '0;
    if (hdr_slot != '0) hdr_base = first_size + ((5'(hdr_slot) - 5'd1) * max_size);
    hdr_idx = hdr_base + slot_cnt[hdr_slot];
    hdr_bad = (desc.status != 3'b000) || desc.poisoned ||
              (desc.dword_count[2:0] != 3'b000) || (hdr_idx >= bd_num) ||
              (s_axis_rc_tlast && (desc.dword_count > 11'd5));
  end

  // Each DATA beat completes one BD from the held tail plus the new beat's head
  assign buf_wr_en = rc_fire && (state == S_DATA) && !drop && (wr_idx < bd_num);

  assign m_axis_bd_tvalid = busy & rd_valid;
  assign m_axis_bd_tlast  = busy && ({1'b0, rd_ptr} == bd_num - 5'd1);
  assign bd_fire          = m_axis_bd_tvalid & m_axis_bd_tready;

  bd_reorder_buf #(
    .DEPTH (MAX_BD),
    .IDX_W (IDX_W)
  ) u_buf (
    .user_clk   (user_clk),
    .user_reset (user_reset),
    .wr_en      (buf_wr_en),
    .wr_idx     (wr_idx[IDX_W-1:0]),
    .wr_data    ({s_axis_rc_tdata[RC_PAYLOAD_LSB-1:0], hold}),
    .rd_idx     (rd_ptr),
    .rd_clr     (bd_fire),
    .rd_valid   (rd_valid),
    .rd_data    (m_axis_bd_tdata)
  );

  // Payload tail carried into the next beat's BD
  always_ff @(posedge user_clk) begin
    if (rc_fire) hold <= s_axis_rc_tdata[BD_W-1:RC_PAYLOAD_LSB];
  end

  // Request FSM, per-slot write counters and output read pointer
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state      <= S_IDLE;
      bd_num     <= '0;
      first_size <= '0;
      max_size   <= '0;
      cur_slot   <= '0;
      wr_idx     <= '0;
      drop       <= 1'b0;
      rd_ptr     <= '0;
      bd_cpl_err <= 1'b0;
      for (int s = 0; s < NSLOT; s++) slot_cnt[s] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_start) begin
            state      <= S_HDR;
            bd_num     <= req_bd_num;
            first_size <= req_first_size;
            max_size   <= mrrs_bds(cfg_max_rd_req_size);
            bd_cpl_err <= 1'b0;
            rd_ptr     <= '0;
          end
        end
        S_HDR: begin
          if (rc_fire) begin
            cur_slot <= hdr_slot;
            wr_idx   <= hdr_idx;
            drop     <= hdr_bad;
            if (hdr_bad) bd_cpl_err <= 1'b1;
            if (!s_axis_rc_tlast) state <= S_DATA;
          end
        end
        S_DATA: begin
          if (rc_fire) begin
            if (buf_wr_en) begin
              wr_idx             <= wr_idx + 5'd1;
              slot_cnt[cur_slot] <= slot_cnt[cur_slot] + 5'd1;
            end
            if (s_axis_rc_tlast) state <= S_HDR;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (bd_fire) begin
        rd_ptr <= rd_ptr + IDX_W'(1);
        if (m_axis_bd_tlast) begin
          state <= S_IDLE;
          for (int s = 0; s < NSLOT; s++) slot_cnt[s] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bd_cpld_recv.sv
// Self-checking bench for bd_cpld_recv: table of requests (config, TLP order)
// plus hand-written error, latency and reset sequences. Expected BDs are
// queued in address order when a request starts and compared on each output.
module tb_bd_cpld_recv;

  logic         user_clk = 1'b0;
  logic         user_reset;
  logic [2:0]   cfg_max_rd_req_size;
  logic         req_start;
  logic [4:0]   req_bd_num;
  logic [4:0]   req_first_size;
  logic         req_ready;
  logic         s_axis_rc_tvalid;
  logic         s_axis_rc_tready;
  logic [255:0] s_axis_rc_tdata;
  logic         s_axis_rc_tlast;
  logic         m_axis_bd_tvalid;
  logic         m_axis_bd_tready;
  logic [255:0] m_axis_bd_tdata;
  logic         m_axis_bd_tlast;
  logic         bd_cpl_err;

  bd_cpld_recv dut (
    .user_clk            (user_clk),
    .user_reset          (user_reset),
    .cfg_max_rd_req_size (cfg_max_rd_req_size),
    .req_start           (req_start),
    .req_bd_num          (req_bd_num),
    .req_first_size      (req_first_size),
    .req_ready           (req_ready),
    .s_axis_rc_tvalid    (s_axis_rc_tvalid),
    .s_axis_rc_tready    (s_axis_rc_tready),
    .s_axis_rc_tdata     (s_axis_rc_tdata),
    .s_axis_rc_tlast     (s_axis_rc_tlast),
    .m_axis_bd_tvalid    (m_axis_bd_tvalid),
    .m_axis_bd_tready    (m_axis_bd_tready),
    .m_axis_bd_tdata     (m_axis_bd_tdata),
    .m_axis_bd_tlast     (m_axis_bd_tlast),
    .bd_cpl_err          (bd_cpl_err)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [255:0] data;
    logic         last;
  } exp_t;

  typedef struct {
    logic [2:0] cfg;
    int         num;
    int         first;
    int         ntlp;
    int         tag [4];
    int         nbd [4];
    bit         stall;
    bit         hold_chk;
    logic       exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rid      = 0;
  int   m_num, m_first, m_max;
  int   m_cnt [4];
  bit   chk_ready_next = 1'b0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check_word(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Recognisable BD content: each DW = {request id, BD index, DW index, 0x5A}
  function automatic logic [255:0] bd_val(input int r, input int idx);
    logic [255:0] v;
    for (int dw = 0; dw < 8; dw++) v[dw*32 +: 32] = {r[7:0], idx[7:0], dw[7:0], 8'h5A};
    return v;
  endfunction

  function automatic int model_base(input int slot);
    return (slot == 0) ? 0 : m_first + (slot - 1) * m_max;
  endfunction

  task automatic set_vec(input int i, input logic [2:0] cfg, input int num, input int first,
                         input int ntlp, input int t0, input int n0, input int t1, input int n1,
                         input int t2, input int n2, input int t3, input int n3,
                         input bit stall, input bit hold_chk);
    vecs[i].cfg = cfg;   vecs[i].num = num;  vecs[i].first = first; vecs[i].ntlp = ntlp;
    vecs[i].tag[0] = t0; vecs[i].nbd[0] = n0; vecs[i].tag[1] = t1; vecs[i].nbd[1] = n1;
    vecs[i].tag[2] = t2; vecs[i].nbd[2] = n2; vecs[i].tag[3] = t3; vecs[i].nbd[3] = n3;
    vecs[i].stall = stall; vecs[i].hold_chk = hold_chk; vecs[i].exp_err = 1'b0;
  endtask

  task automatic start_req(input logic [2:0] cfg, input int num, input int first);
    exp_t e;
    check_bit("req_ready_before_start", req_ready, 1'b1);
    rid++;
    cfg_max_rd_req_size = cfg;
    req_bd_num          = 5'(num);
    req_first_size      = 5'(first);
    req_start           = 1'b1;
    @(posedge user_clk); #1;
    req_start = 1'b0;
    m_num   = num;
    m_first = first;
    m_max   = (cfg == 3'b000) ? 4 : (cfg == 3'b001) ? 8 : 16;
    m_cnt   = '{default: 0};
    for (int i = 0; i < num; i++) begin
      e.data = bd_val(rid, i);
      e.last = (i == num - 1);
      sb.push_back(e);
    end
  endtask

  // One completion TLP of n BDs for the given tag, split into 256-bit beats
  task automatic send_tlp(input int tag, input int n, input int dwc, input logic [2:0] status);
    logic [95:0]  d;
    logic [255:0] cur, prev;
    int           idx0;
    idx0 = model_base(tag) + m_cnt[tag];
    d = '0;
    d[11:0]  = 12'(idx0 * 32);
    d[42:32] = 11'(dwc);
    d[45:43] = status;
    d[71:64] = 8'(tag);
    check_bit("rc_tready_busy", s_axis_rc_tready, 1'b1);
    cur = bd_val(rid, idx0);
    s_axis_rc_tvalid = 1'b1;
    s_axis_rc_tdata  = {cur[159:0], d};
    s_axis_rc_tlast  = (n == 0);
    @(posedge user_clk); #1;
    for (int k = 1; k <= n; k++) begin
      prev = cur;
      cur  = (k < n) ? bd_val(rid, idx0 + k) : '0;
      s_axis_rc_tdata = {cur[159:0], prev[255:160]};
      s_axis_rc_tlast = (k == n);
      @(posedge user_clk); #1;
    end
    s_axis_rc_tvalid = 1'b0;
    s_axis_rc_tlast  = 1'b0;
    if (status == 3'b000 && idx0 < m_num) m_cnt[tag] += n;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!(sb.size() == 0 && req_ready) && cyc < 400) begin
      @(posedge user_clk); #1;
      cyc++;
    end
    check_bit(name, (sb.size() == 0 && req_ready), 1'b1);
  endtask

  // Output monitor: pops the scoreboard on every BD handshake
  always @(negedge user_clk) begin : mon
    exp_t e;
    if (!user_reset) begin
      if (chk_ready_next) begin
        check_bit("req_ready_after_last", req_ready, 1'b1);
        chk_ready_next = 1'b0;
      end
      if (m_axis_bd_tvalid && m_axis_bd_tready) begin
        if (sb.size() == 0) begin
          check_bit("unexpected_bd", m_axis_bd_tvalid, 1'b0);
        end else begin
          e = sb.pop_front();
          check_word("bd_data", m_axis_bd_tdata, e.data);
          check_bit("bd_last", m_axis_bd_tlast, e.last);
          if (e.last) chk_ready_next = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    user_reset          = 1'b1;
    cfg_max_rd_req_size = 3'b000;
    req_start           = 1'b0;
    req_bd_num          = '0;
    req_first_size      = '0;
    s_axis_rc_tvalid    = 1'b0;
    s_axis_rc_tdata     = '0;
    s_axis_rc_tlast     = 1'b0;
    m_axis_bd_tready    = 1'b1;

    //        idx cfg     num first ntlp  tag,nbd pairs          stall hold
    set_vec(0, 3'b010,  3,  3,  1,   0, 3, 0, 0, 0, 0, 0, 0,  0, 0);
    set_vec(1, 3'b000, 10,  2,  3,   2, 4, 0, 2, 1, 4, 0, 0,  0, 1);
    set_vec(2, 3'b000,  4,  4,  2,   0, 2, 0, 2, 0, 0, 0, 0,  0, 0);
    set_vec(3, 3'b000,  8,  4,  2,   1, 4, 0, 4, 0, 0, 0, 0,  1, 0);
    set_vec(4, 3'b000, 16,  5,  4,   3, 3, 1, 4, 0, 5, 2, 4,  0, 1);
    set_vec(5, 3'b011,  1,  1,  1,   0, 1, 0, 0, 0, 0, 0, 0,  0, 0);

    repeat (3) @(posedge user_clk);
    #1;
    check_bit("rst_req_ready", req_ready, 1'b1);
    check_bit("rst_rc_tready", s_axis_rc_tready, 1'b0);
    check_bit("rst_bd_tvalid", m_axis_bd_tvalid, 1'b0);
    check_bit("rst_bd_tlast",  m_axis_bd_tlast, 1'b0);
    check_bit("rst_cpl_err",   bd_cpl_err, 1'b0);
    user_reset = 1'b0;
    @(posedge user_clk); #1;

    // Table-driven requests
    for (int v = 0; v < 6; v++) begin
      m_axis_bd_tready = !vecs[v].stall;
      start_req(vecs[v].cfg, vecs[v].num, vecs[v].first);
      for (int t = 0; t < vecs[v].ntlp; t++) begin
        send_tlp(vecs[v].tag[t], vecs[v].nbd[t], 8 * vecs[v].nbd[t], 3'b000);
        if (t == 0 && vecs[v].hold_chk) check_bit("no_out_before_slot0", m_axis_bd_tvalid, 1'b0);
      end
      if (vecs[v].stall) begin
        repeat (20) begin
          @(posedge user_clk); #1;
        end
        check_bit("stall_rc_tready", s_axis_rc_tready, 1'b1);
        check_bit("stall_bd_pending", m_axis_bd_tvalid, 1'b1);
        m_axis_bd_tready = 1'b1;
      end
      wait_done("vec_done");
      check_bit("vec_err", bd_cpl_err, vecs[v].exp_err);
    end

    // Bad-status completion: dropped, sticky error, then last-BD latency
    m_axis_bd_tready = 1'b0;
    start_req(3'b000, 1, 1);
    send_tlp(0, 1, 8, 3'b001);
    check_bit("err_bad_status", bd_cpl_err, 1'b1);
    check_bit("no_write_on_bad", m_axis_bd_tvalid, 1'b0);
    send_tlp(0, 1, 8, 3'b000);
    check_bit("last_bd_latency", m_axis_bd_tvalid, 1'b1);
    check_bit("err_sticky", bd_cpl_err, 1'b1);
    m_axis_bd_tready = 1'b1;
    wait_done("err_req_done");
    check_bit("err_held_in_idle", bd_cpl_err, 1'b1);

    // New request clears the error; an out-of-range slot sets it again
    start_req(3'b000, 1, 1);
    check_bit("err_cleared", bd_cpl_err, 1'b0);
    send_tlp(1, 1, 8, 3'b000);
    check_bit("err_out_of_range", bd_cpl_err, 1'b1);
    send_tlp(0, 1, 8, 3'b000);
    wait_done("oor_req_done");

    // Reset after 2 of 5 BDs delivered
    m_axis_bd_tready = 1'b0;
    start_req(3'b001, 5, 5);
    send_tlp(0, 5, 40, 3'b000);
    m_axis_bd_tready = 1'b1;
    @(posedge user_clk);
    @(posedge user_clk); #1;
    m_axis_bd_tready = 1'b0;
    user_reset = 1'b1;
    #1;
    check_bit("mid_rst_tvalid", m_axis_bd_tvalid, 1'b0);
    check_bit("mid_rst_req_ready", req_ready, 1'b1);
    check_bit("mid_rst_rc_tready", s_axis_rc_tready, 1'b0);
    check_word("mid_rst_consumed", 256'(sb.size()), 256'(3));
    sb.delete();
    chk_ready_next = 1'b0;
    repeat (2) @(posedge user_clk);
    #1;
    user_reset = 1'b0;
    m_axis_bd_tready = 1'b1;
    @(posedge user_clk); #1;
    check_bit("post_rst_no_bd", m_axis_bd_tvalid, 1'b0);
    start_req(3'b000, 1, 1);
    send_tlp(0, 1, 8, 3'b000);
    wait_done("post_rst_done");
    check_bit("post_rst_err", bd_cpl_err, 1'b0);

    repeat (3) @(posedge user_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
